// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the unified memory arbiter
interface mem_port_arbiter_if;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_ack;
   logic [63:0] if_rdata;
   logic        if_stall;

   logic        dm_req;
   logic        dm_we;
   logic [63:0] dm_addr;
   logic [63:0] dm_wdata;
   logic        dm_ack;
   logic [63:0] dm_rdata;
   logic        dm_stall;

   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   // arbiter side
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, if_stall, dm_ack, dm_rdata, dm_stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   // pipeline ports and memory side
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, if_stall, dm_ack, dm_rdata, dm_stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises IF and MEM stage accesses onto one fixed-latency memory
// Data port wins contention until STARVE_MAX consecutive contended grants, then fetch is forced.
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus,
   output logic              busy,
   output logic              grant_dm
);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT - 1);
   localparam logic [3:0]    STREAK_CAP = 4'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic [3:0]    streak;
   logic          is_store;
   logic          any_req;
   logic          pick_dm;

   logic          mem_req_q, mem_we_q;
   logic [63:0]   mem_addr_q, mem_wdata_q;
   logic          if_ack_q, dm_ack_q;
   logic [63:0]   if_rdata_q, dm_rdata_q;

   always_comb begin
      any_req    = bus.if_req || bus.dm_req;
      pick_dm    = bus.dm_req && (!bus.if_req || (streak != STREAK_CAP));
      state_next = state;
      case (state)
         IDLE:    if (any_req) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (cnt == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         streak      <= '0;
         is_store    <= 1'b0;
         busy        <= 1'b0;
         grant_dm    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state       <= state_next;
         busy        <= (state_next != IDLE);
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  // The issue-cycle registers double as the latched copy of the request
                  grant_dm    <= pick_dm;
                  is_store    <= pick_dm && bus.dm_we;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= pick_dm && bus.dm_we;
                  mem_addr_q  <= pick_dm ? bus.dm_addr : bus.if_addr;
                  mem_wdata_q <= pick_dm ? bus.dm_wdata : '0;
                  if (pick_dm && bus.if_req)
                     streak <= (streak == STREAK_CAP) ? STREAK_CAP : streak + 4'd1;
                  else
                     streak <= '0;
               end
            end
            ISSUE: cnt <= LAT_LOAD;
            WAIT: begin
               if (cnt == '0) begin
                  if (grant_dm) begin
                     dm_ack_q   <= 1'b1;
                     dm_rdata_q <= is_store ? '0 : bus.mem_rdata;
                  end else begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= bus.mem_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_stall  = bus.if_req && !if_ack_q;
   assign bus.dm_stall  = bus.dm_req && !dm_ack_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported, fixed-latency unified memory between the instruction-fetch port (IF stage) and the data-memory port (MEM stage) of the 5-stage RISC-V pipeline. It serialises accesses, returns read data with a one-cycle acknowledge, and raises per-port stall signals that the pipeline uses to freeze the Program_Counter, IF_ID and downstream pipeline registers. The data port has priority, with a starvation guard that guarantees fetch progress.

## Interface
- MEM_LAT, 2, memory read latency in cycles from the issue cycle to valid `mem_rdata` (legal ≥1)
- STARVE_MAX, 4, consecutive contended data grants allowed before fetch is forced (legal 1..15)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- if_req  input  1  fetch request; held stable with if_addr until if_ack
- if_addr  input  64  fetch byte address
- if_ack  output  1  one-cycle pulse: fetch done, if_rdata valid
- if_rdata  output  64  fetch read data, valid only while if_ack
- if_stall  output  1  combinational: if_req && !if_ack
- dm_req  input  1  data request; held stable with dm_we/dm_addr/dm_wdata until dm_ack
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  64  data byte address
- dm_wdata  input  64  store data
- dm_ack  output  1  one-cycle pulse: data access done
- dm_rdata  output  64  load data while dm_ack on a load; 0 on store ack
- dm_stall  output  1  combinational: dm_req && !dm_ack
- mem_req  output  1  registered; high for exactly the issue cycle
- mem_we  output  1  registered write enable, valid with mem_req
- mem_addr  output  64  registered address, valid with mem_req
- mem_wdata  output  64  registered write data, valid with mem_req
- mem_rdata  input  64  memory read data, valid MEM_LAT cycles after issue
- busy  output  1  high in every state except IDLE
- grant_dm  output  1  owner of current access: 1 = data, 0 = fetch

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset → IDLE.
- IDLE: no request → stay. Request(s) pending → latch owner, addr, we, wdata; go ISSUE.
- Owner selection: only one requesting → that one. Both → data, unless streak == STARVE_MAX → fetch.
- streak (4-bit): on data grant with if_req high → streak+1 (saturate at STARVE_MAX); on fetch grant or data grant with if_req low → 0.
- ISSUE (1 cycle): mem_req=1, mem_we/addr/wdata from latch (mem_we forced 0 for fetch); load counter with MEM_LAT-1; go WAIT.
- WAIT (MEM_LAT cycles): counter decrements; in the final WAIT cycle (counter==0) capture mem_rdata (read only); go DONE.
- DONE (1 cycle): pulse owner's ack; rdata output = captured data (store: 0); go IDLE unconditionally.
- Non-owner port's ack is 0 and its rdata is 0 at all times outside its own DONE.
- Requester changes to inputs after grant are ignored (latched copy used); protocol still requires holding until ack.
- Dropping a request before ack is a protocol violation; the started access still completes and acks.

## Timing
- Reset values: state IDLE, streak 0, counter 0, all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, busy, grant_dm).
- Request first seen in IDLE cycle t → mem_req cycle t+1 → data captured end of cycle t+1+MEM_LAT → ack cycle t+2+MEM_LAT. MEM_LAT=2: request 0, issue 1, wait 2–3, ack 4.
- Minimum spacing between issues: MEM_LAT+3 cycles (DONE always returns to IDLE).
- Request asserted during ISSUE/WAIT/DONE is not granted until the next IDLE cycle.
- Simultaneous if_req and dm_req in IDLE: arbitration per streak rule; loser's stall stays high throughout.
- reset during ISSUE/WAIT/DONE: next cycle IDLE, all outputs 0, no ack for the aborted access, late mem_rdata ignored, streak cleared.
- if_stall/dm_stall are the only combinational outputs; fall in the ack cycle.

## Test plan
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x10 at cycle 0, mem_rdata=0x00A00093 in cycle 3 → mem_req=1/mem_addr=0x10/mem_we=0 cycle 1; if_ack=1, if_rdata=0x00A00093 cycle 4; if_stall 1 in cycles 0–3.
- Store: dm_req=1, dm_we=1, dm_addr=0x20, dm_wdata=0x55 → cycle 1 mem_we=1, mem_wdata=0x55; dm_ack cycle 4 with dm_rdata=0.
- Contention: if_req and dm_req both high from cycle 0, held until ack → data acked cycle 4, fetch issued cycle 6, fetch acked cycle 9.
- Starvation, STARVE_MAX=4: if_req held high, dm_req re-asserted immediately after each ack → 4 data grants, 5th grant to fetch (grant_dm=0), streak returns to 0.
- Reset mid-access: issue load, assert reset in first WAIT cycle → next cycle all outputs 0, state IDLE, no dm_ack ever; new request afterwards completes in MEM_LAT+2 cycles.
- MEM_LAT=1 build: load request cycle 0 → issue 1, wait 2, ack 3 with correct data.
